// File: rtl/stopwatch_pkg.sv
// Shared definitions for the hex stopwatch: state encoding and default
// timing parameters. Used by the controller, the digit counter and the
// display path so that all of them agree on the state values.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    // 1 s per increment and 20 ms of debounce at a 50 MHz clock.
    localparam int DEFAULT_TICK_DIV        = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/stopwatch_controller_button_conditioner.sv
// button_conditioner: turns one raw, bouncing, asynchronous pushbutton into
// a single-cycle press pulse.
//   clock  : system clock
//   reset  : synchronous active-high reset
//   btn    : raw button level, active high, asynchronous to clock
//   press  : one-cycle pulse on an accepted rising edge of the button
// Path: 2-flop synchronizer -> debounce counter -> registered edge detect.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          level_prev_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            // Level starts as "pressed": a button held through reset must be
            // released and pressed again before it produces a pulse.
            level_reg      <= 1'b1;
            level_prev_reg <= 1'b1;
            press_reg      <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            sync1_reg      <= btn;
            sync2_reg      <= sync1_reg;
            level_prev_reg <= level_reg;
            press_reg      <= level_reg & ~level_prev_reg;
            // Count consecutive cycles of disagreement; any agreeing cycle
            // restarts the count. The level flips on the last one.
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: pushbutton conditioning, run/pause/lap state
// machine and the one-second prescaler for the four-digit hex stopwatch.
//   clock, reset : system clock, synchronous active-high reset
//   btn_start    : raw start/stop pushbutton
//   btn_lap      : raw lap/reset pushbutton
//   count_full   : digit counter reports FFFF
//   tick         : one-cycle increment strobe to the digit counter
//   clear        : one-cycle clear strobe to the digit counter
//   lap_latch    : one-cycle strobe to capture the count into the lap register
//   display_hold : 1 = show lap register, 0 = show live count
//   state        : IDLE=0, RUN=1, PAUSE=2, DONE=3
// All outputs come straight from registers.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       count_full,
    output logic       tick,
    output logic       clear,
    output logic       lap_latch,
    output logic       display_hold,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // Index 0 = start/stop, index 1 = lap/reset.
    logic [1:0] btn_raw;
    logic [1:0] press_vec;

    assign btn_raw = {btn_lap, btn_start};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cond (
                .clock(clock),
                .reset(reset),
                .btn  (btn_raw[gi]),
                .press(press_vec[gi])
            );
        end
    endgenerate

    sw_state_e     state_reg,     state_next;
    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic          hold_reg,      hold_next;
    logic          tick_reg,      tick_next;
    logic          clear_reg,     clear_next;
    logic          lap_latch_reg, lap_latch_next;

    logic start_press;
    logic lap_press;
    logic run_step;

    // Start wins over a simultaneous lap press.
    assign start_press = press_vec[0];
    assign lap_press   = press_vec[1] & ~press_vec[0];

    // The prescaler advances on every RUN cycle except the one that pauses,
    // and also on the resume edge, so a held value p gives its next tick
    // TICK_DIV-1-p cycles after RUN is re-entered.
    assign run_step = ((state_reg == ST_RUN)   && !start_press) ||
                      ((state_reg == ST_PAUSE) &&  start_press);

    always_comb begin
        state_next     = state_reg;
        prescaler_next = prescaler_reg;
        hold_next      = hold_reg;
        tick_next      = 1'b0;
        clear_next     = 1'b0;
        lap_latch_next = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start_press) begin
                    state_next     = ST_RUN;
                    prescaler_next = '0;
                end
            end
            ST_RUN: begin
                if (start_press) begin
                    state_next = ST_PAUSE;
                end else if (lap_press) begin
                    hold_next      = ~hold_reg;
                    lap_latch_next = ~hold_reg;
                end
            end
            ST_PAUSE: begin
                if (start_press) begin
                    state_next = ST_RUN;
                end else if (lap_press) begin
                    if (hold_reg) begin
                        hold_next = 1'b0;
                    end else begin
                        clear_next     = 1'b1;
                        state_next     = ST_IDLE;
                        prescaler_next = '0;
                    end
                end
            end
            ST_DONE: begin
                hold_next = 1'b0;
                if (lap_press) begin
                    clear_next     = 1'b1;
                    state_next     = ST_IDLE;
                    prescaler_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (run_step) begin
            if (prescaler_reg == PRESC_LAST) begin
                prescaler_next = '0;
                if (count_full) begin
                    // Counter saturated: stop instead of wrapping FFFF->0000.
                    state_next = ST_DONE;
                    hold_next  = 1'b0;
                end else begin
                    tick_next = 1'b1;
                end
            end else begin
                prescaler_next = prescaler_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            prescaler_reg <= '0;
            hold_reg      <= 1'b0;
            tick_reg      <= 1'b0;
            clear_reg     <= 1'b0;
            lap_latch_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prescaler_reg <= prescaler_next;
            hold_reg      <= hold_next;
            tick_reg      <= tick_next;
            clear_reg     <= clear_next;
            lap_latch_reg <= lap_latch_next;
        end
    end

    assign tick         = tick_reg;
    assign clear        = clear_reg;
    assign lap_latch    = lap_latch_reg;
    assign display_hold = hold_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Testbench for stopwatch_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A behavioural model runs beside the DUT on every rising edge; all DUT
// outputs are compared against it on every falling edge.
module tb_stopwatch_controller;

    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int HLEN = DEB + 2;

    logic       clock;
    logic       reset;
    logic       btn_start;
    logic       btn_lap;
    logic       count_full;
    logic       tick;
    logic       clear;
    logic       lap_latch;
    logic       display_hold;
    logic [1:0] state;

    stopwatch_controller #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .count_full  (count_full),
        .tick        (tick),
        .clear       (clear),
        .lap_latch   (lap_latch),
        .display_hold(display_hold),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    // Stopwatch mode: 0 idle, 1 run, 2 pause, 3 done.
    int m_state, m_presc, m_hold, m_tick, m_clear, m_latch;
    // Per button: raw samples taken at each edge, newest first. Value 2 marks
    // "no sample yet" (never counts as disagreeing with the debounced level).
    int hist [2][HLEN];
    // Debounced level after the latest edges, newest first.
    int lvl  [2][3];
    int m_press [2];

    task model_advance();
        if (m_presc == TD - 1) begin
            m_presc = 0;
            if (count_full) begin
                m_state = 3;
                m_hold  = 0;
            end else begin
                m_tick = 1;
            end
        end else begin
            m_presc = m_presc + 1;
        end
    endtask

    always @(posedge clock) begin
        int sp, lp, flip, want;
        if (reset) begin
            m_state = 0; m_presc = 0; m_hold = 0;
            m_tick = 0; m_clear = 0; m_latch = 0;
            for (int b = 0; b < 2; b++) begin
                hist[b][0] = 0;
                hist[b][1] = 0;
                for (int i = 2; i < HLEN; i++) hist[b][i] = 2;
                for (int i = 0; i < 3; i++) lvl[b][i] = 1;
                m_press[b] = 0;
            end
        end else begin
            sp = m_press[0];
            lp = m_press[1] && !sp;
            m_tick = 0; m_clear = 0; m_latch = 0;
            if (sp || lp)
                $display("t=%0t press %s in mode %0d hold=%0d presc=%0d",
                         $time, sp ? "start" : "lap", m_state, m_hold, m_presc);
            case (m_state)
                0: if (sp) begin m_state = 1; m_presc = 0; end
                1: begin
                    if (sp) m_state = 2;
                    else begin
                        if (lp) begin m_hold = !m_hold; m_latch = m_hold; end
                        model_advance();
                    end
                end
                2: begin
                    if (sp) begin m_state = 1; model_advance(); end
                    else if (lp) begin
                        if (m_hold) m_hold = 0;
                        else begin m_clear = 1; m_state = 0; m_presc = 0; end
                    end
                end
                default: begin
                    m_hold = 0;
                    if (lp) begin m_clear = 1; m_state = 0; m_presc = 0; end
                end
            endcase
            for (int b = 0; b < 2; b++) begin
                for (int i = HLEN - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = (b == 0) ? int'(btn_start) : int'(btn_lap);
                // Level follows the synchronized input once DEB consecutive
                // synchronized samples all disagree with it.
                want = 1 - lvl[b][0];
                flip = 1;
                for (int i = 2; i < DEB + 2; i++)
                    if (hist[b][i] != want) flip = 0;
                lvl[b][2] = lvl[b][1];
                lvl[b][1] = lvl[b][0];
                lvl[b][0] = flip ? want : lvl[b][0];
                m_press[b] = (lvl[b][1] == 1 && lvl[b][2] == 0) ? 1 : 0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit visited [4];
    int tick_seen = 0;
    int clear_seen = 0;
    int latch_seen = 0;

    always @(negedge clock) begin
        if (checking) begin
            check("state",        state,        m_state);
            check("tick",         tick,         m_tick);
            check("clear",        clear,        m_clear);
            check("lap_latch",    lap_latch,    m_latch);
            check("display_hold", display_hold, m_hold);
            check("tick_clear_excl", tick & clear, 0);
            visited[state] = 1'b1;
            if (tick)      tick_seen++;
            if (clear)     clear_seen++;
            if (lap_latch) latch_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_btn(input int b, input int hold);
        if (b == 0) btn_start = 1'b1; else btn_lap = 1'b1;
        cyc(hold);
        if (b == 0) btn_start = 1'b0; else btn_lap = 1'b0;
        cyc(hold);
    endtask

    task automatic press_both();
        btn_start = 1'b1; btn_lap = 1'b1;
        cyc(6);
        btn_start = 1'b0; btn_lap = 1'b0;
        cyc(6);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cyc(n);
        reset = 1'b0;
    endtask

    initial begin
        int rem0, rem1;
        reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; count_full = 1'b0;
        cyc(3);
        checking = 1;
        reset = 1'b0;
        cyc(2);

        // Clean start, let it tick a few times.
        press_btn(0, 6);
        cyc(13);

        // Bounces shorter than the debounce window.
        for (int i = 0; i < 12; i++) begin
            btn_start = ~btn_start;
            cyc($urandom_range(1, 2));
        end
        btn_start = 1'b0;
        cyc(8);

        // Held through reset: no press after reset.
        btn_start = 1'b1;
        cyc(6);
        do_reset(2);
        cyc(10);
        btn_start = 1'b0;
        cyc(10);

        // Pause/resume at each prescaler phase.
        for (int d = 0; d < 4; d++) begin
            press_btn(0, 6);
            cyc(d);
            press_btn(0, 6);
            cyc(20);
            press_btn(0, 6);
            cyc(9);
            press_btn(0, 6);
            press_btn(1, 6);
            cyc(4);
        end

        // Laps in RUN, then in PAUSE.
        press_btn(0, 6);
        press_btn(1, 6);
        cyc(5);
        press_btn(1, 6);
        press_btn(1, 6);
        press_btn(0, 6);
        press_btn(1, 6);
        press_btn(1, 6);
        cyc(4);

        // Counter saturation.
        press_btn(0, 6);
        count_full = 1'b1;
        cyc(8);
        press_btn(0, 6);
        count_full = 1'b0;
        press_btn(1, 6);
        cyc(4);

        // Simultaneous presses in PAUSE with hold set.
        press_btn(0, 6);
        press_btn(1, 6);
        press_btn(0, 6);
        press_both();
        cyc(6);

        // Reset mid-run.
        do_reset(1);
        cyc(12);

        // Randomized button activity.
        rem0 = 1; rem1 = 1;
        for (int c = 0; c < 4000; c++) begin
            rem0--; rem1--;
            if (rem0 == 0) begin
                btn_start = ~btn_start;
                rem0 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            end
            if (rem1 == 0) begin
                btn_lap = ~btn_lap;
                rem1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            end
            if ($urandom_range(0, 15) == 0) count_full = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(4);

        // Coverage sanity: every mode reached and every strobe exercised.
        check("visited_idle",  visited[0], 1);
        check("visited_run",   visited[1], 1);
        check("visited_pause", visited[2], 1);
        check("visited_done",  visited[3], 1);
        check("tick_seen",   tick_seen  > 0, 1);
        check("clear_seen",  clear_seen > 0, 1);
        check("latch_seen",  latch_seen > 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Control sequencer for the four-digit hexadecimal stopwatch. It conditions the start/stop and lap/reset pushbuttons and runs the stopwatch state machine. It generates the one-second increment strobe, the clear strobe and the lap-display controls that drive the existing hex digit counter and seven-segment decode path. It sits between the board pushbuttons and the digit counter, replacing the raw pause and reset switch levels.

## Interface
Parameters:
- TICK_DIV, 50000000: clock cycles per count increment (1 s at 50 MHz).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before a button level is accepted (20 ms).

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- btn_start  in  1  raw start/stop pushbutton, active high, asynchronous to clock.
- btn_lap  in  1  raw lap/reset pushbutton, active high, asynchronous to clock.
- count_full  in  1  from digit counter: all four digits equal F.
- tick  out  1  one-cycle increment strobe to digit counter.
- clear  out  1  one-cycle clear strobe to digit counter.
- lap_latch  out  1  one-cycle strobe: capture current count into lap register.
- display_hold  out  1  1 = display shows lap register, 0 = live count.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Per button: 2-flop synchronizer, then debounce counter, then rising-edge detector. The result is a one-cycle press pulse.
- The debounced level updates only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle restarts the count.
- The debounced level resets to 1 (pressed), so a button held through reset produces no press until it is released and pressed again.
- Simultaneous start_press and lap_press: start wins, lap is dropped.
- IDLE: start_press goes to RUN with prescaler = 0. lap_press is ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At terminal count, if count_full = 0, tick = 1. If count_full = 1, no tick and go to DONE.
  - start_press goes to PAUSE; the prescaler holds its value.
  - lap_press toggles display_hold. On the 0→1 transition, lap_latch pulses.
- PAUSE: prescaler frozen.
  - start_press goes to RUN and resumes from the held prescaler value.
  - lap_press with display_hold = 1 clears display_hold and stays in PAUSE.
  - lap_press with display_hold = 0 pulses clear, goes to IDLE, and sets prescaler = 0.
- DONE: display_hold forced to 0, no ticks.
  - lap_press pulses clear, goes to IDLE, and sets prescaler = 0.
  - start_press is ignored.
- Reset, at any time including mid-RUN: state = IDLE, prescaler = 0, debounce counters = 0, tick/clear/lap_latch/display_hold = 0. Reset does not pulse clear; the digit counter uses the same reset.
- Widths: prescaler $clog2(TICK_DIV). Debounce counter $clog2(DEBOUNCE_CYCLES+1). No arithmetic beyond terminal-count compare and wrap.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Press latency: raw edge, then 2 sync cycles, then DEBOUNCE_CYCLES stable cycles, then debounced level changes. The press pulse follows one cycle later, and state/outputs update on the next edge.
- First tick occurs TICK_DIV cycles after the cycle state becomes RUN from IDLE. Subsequent ticks are exactly TICK_DIV cycles apart.
- Resume from PAUSE with held prescaler p: the next tick comes TICK_DIV-1-p cycles after state becomes RUN.
- clear and lap_latch are asserted in the same cycle as the corresponding state/display_hold change, for exactly one cycle.
- tick and clear are never asserted in the same cycle.

## Structure
- Package stopwatch_pkg:
  - state encoding constants (IDLE, RUN, PAUSE, DONE);
  - default TICK_DIV and DEBOUNCE_CYCLES.
- The package is shared with the digit counter and display modules.
- Sub-module button_conditioner (synchronizer + debounce + edge detect), parameterized by DEBOUNCE_CYCLES and instantiated twice.
- FSM and prescaler live in the top module.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_CYCLES=3.
- Reset, then clean start press → state=1. tick pulses 4 cycles after RUN entry, then every 4 cycles; clear stays 0.
- btn_start toggles with runs shorter than 3 cycles → no state change. Held stable for 3+ cycles → exactly one transition. Holding the button through reset → no press after reset.
- Pause when prescaler=2, wait 20 cycles, resume → no ticks while paused. Next tick arrives 1 cycle after state returns to 1.
- Lap in RUN → lap_latch=1 for one cycle, display_hold=1, ticks continue. Second lap → display_hold=0, no lap_latch. In PAUSE with hold=1, lap → hold=0, state stays 2. Lap again → clear pulse, state=0.
- count_full=1 held at terminal count → no tick, state=3. start ignored. Lap → clear for 1 cycle, state=0.
- Start and lap pressed the same cycle in PAUSE → state=1, display_hold unchanged. Reset asserted mid-RUN → next cycle state=0, all strobes 0, no further ticks.
